// File: rtl/ahbl_defs.sv
// Shared AHB-Lite encodings and the AHB-to-APB bridge state encoding.
package ahbl_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  // The APB side carries at most one 32-bit word per transfer.
  function automatic logic size_ok(input logic [2:0] hsize);
    return hsize <= HSIZE_WORD;
  endfunction

endpackage

// File: rtl/ahbl_apb_strb.sv
// Byte-lane strobe generation from AHB size/address; reads produce no strobes.
module ahbl_apb_strb
  import ahbl_defs::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] haddr_lo,
  input  logic       hwrite,
  output logic [3:0] pstrb
);

  always_comb begin
    pstrb = 4'b0000;
    if (hwrite) begin
      case (hsize)
        HSIZE_BYTE: pstrb = 4'b0001 << haddr_lo;
        HSIZE_HALF: pstrb = 4'b0011 << {haddr_lo[1], 1'b0};
        HSIZE_WORD: pstrb = 4'b1111;
        default:    pstrb = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave that turns each selected single transfer into one APB4
// SETUP/ACCESS sequence; PSLVERR and oversize transfers return a two-cycle ERROR.
module ahbl_apb_bridge
  import ahbl_defs::*;
#(
  parameter int PADDR_W = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [31:0]        HRDATA,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [PADDR_W-1:0] PADDR,
  output logic [31:0]        PWDATA,
  output logic [3:0]         PSTRB,
  output logic [2:0]         PPROT,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  bridge_state_e state;
  logic [31:0]   pwdata_q;
  logic [3:0]    strb_next;
  logic          capture;
  logic          unused_hbits;

  assign capture      = HSEL & HTRANS[1] & HREADY;
  assign unused_hbits = ^{HADDR[31:PADDR_W], HTRANS[0]};

  ahbl_apb_strb u_strb (
    .hsize    (HSIZE),
    .haddr_lo (HADDR[1:0]),
    .hwrite   (HWRITE),
    .pstrb    (strb_next)
  );

  // Write data arrives in the AHB data phase (SETUP); ACCESS replays the latched copy.
  assign PWDATA = (state == ST_SETUP) ? HWDATA : pwdata_q;
  assign PPROT  = 3'b000;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PSTRB     <= 4'b0000;
      pwdata_q  <= 32'h0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= 32'h0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          PENABLE <= 1'b0;
          if (capture && size_ok(HSIZE)) begin
            state     <= ST_SETUP;
            PSEL      <= 1'b1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_OKAY;
            PADDR     <= {HADDR[PADDR_W-1:2], 2'b00};
            PWRITE    <= HWRITE;
            PSTRB     <= strb_next;
          end else if (capture) begin
            state     <= ST_ERR1;
            PSEL      <= 1'b0;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end else begin
            state     <= ST_IDLE;
            PSEL      <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          PENABLE  <= 1'b1;
          pwdata_q <= HWDATA;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              state <= ST_ERR1;
              HRESP <= HRESP_ERROR;
            end else begin
              state     <= ST_DONE;
              HREADYOUT <= 1'b1;
              if (!PWRITE) HRDATA <= PRDATA;
            end
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: doc/ahbl_apb_bridge.md
# ahbl_apb_bridge

AHB-Lite slave that converts single AHB-Lite transfers into APB4 transfers. It sits directly downstream of one AHB-Lite splitter slave port, typically the peripheral page. It turns one HSEL-qualified AHB transfer into one APB SETUP/ACCESS sequence, inserting AHB wait states until the APB completer responds. PSLVERR is mapped to a two-cycle AHB ERROR response.

## Interface
Parameters:
- PADDR_W, 16: APB address width; PADDR = {HADDR[PADDR_W-1:2], 2'b00}.

Ports (one clock; reset is asynchronous and active-low):
- HCLK  in  1  bus clock, also PCLK.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the splitter.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  transfer type; only bit 1 (NONSEQ/SEQ) starts a transfer.
- HWRITE  in  1  address-phase direction.
- HSIZE  in  3  transfer size.
- HWDATA  in  32  data-phase write data.
- HREADY  in  1  bus-level ready, returned from the splitter.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  registered read data.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  PADDR_W  APB address.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB4 byte strobes.
- PPROT  out  3  fixed 3'b000.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB completer ready.
- PSLVERR  in  1  APB completer error.

## Operation
- Capture condition is HSEL & HTRANS[1] & HREADY. When it is met, the bridge registers HADDR, HWRITE and HSIZE.
- IDLE or BUSY transfers, and transfers that are not selected, get a zero-wait OKAY and produce no APB activity.
- FSM states: IDLE, SETUP, ACCESS, DONE, ERR1, ERR2.
- **IDLE**
  - HREADYOUT=1, HRESP=0.
  - On capture with HSIZE<=2, go to SETUP.
  - On capture with HSIZE>2, go to ERR1 with no APB access.
- **SETUP** (one cycle, the AHB data phase)
  - PSEL=1, PENABLE=0, HREADYOUT=0.
  - PWDATA is driven combinationally from HWDATA and is also registered.
  - Always goes to ACCESS.
- **ACCESS**
  - PSEL=1, PENABLE=1, HREADYOUT=0.
  - PWDATA is driven from the register.
  - Held until PREADY=1.
  - PREADY & ~PSLVERR: HRDATA is loaded with PRDATA on reads (held on writes), then go to DONE.
  - PREADY & PSLVERR: go to ERR1 (HRDATA unchanged).
- **DONE**
  - PSEL=0, HREADYOUT=1, HRESP=0.
  - A capture in DONE goes to SETUP (or ERR1 for a bad size); otherwise go to IDLE.
- **ERR1**: HRESP=1, HREADYOUT=0, PSEL=0. Then go to ERR2.
- **ERR2**
  - HRESP=1, HREADYOUT=1.
  - A capture here is honoured exactly as in DONE, even though the master may cancel it.
- **PSTRB** (writes only; reads drive 4'b0000):
  - byte: 1 << HADDR[1:0]
  - half: 4'b0011 << {HADDR[1],1'b0}
  - word: 4'b1111
- Unaligned half/word addresses are not checked; the low address bits are ignored for PSTRB.
- PADDR, PWRITE and PSTRB are held stable from SETUP through the end of ACCESS.

## Timing
- Reset values:
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0.
  - HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE.
- Reset mid-transfer drops PSEL and PENABLE immediately (asynchronously); the APB transfer is abandoned.
- Minimum latency, PREADY=1 in the first ACCESS cycle:
  - cycle 0: address phase.
  - cycles 1–2: SETUP and ACCESS, HREADYOUT=0.
  - cycle 3: DONE, HREADYOUT=1, HRDATA valid.
  - Total: 2 AHB wait states.
- Each cycle of PREADY=0 adds one wait state.
- Back-to-back transfers:
  - A transfer captured in DONE reaches SETUP in the next cycle; PSEL drops for exactly one cycle between APB transfers.
  - Repeated back-to-back zero-wait transfers therefore complete every 3 cycles.
- HRDATA holds its last value outside DONE.
- Error latency: a bad HSIZE gives ERR1 at cycle 1 and ERR2 at cycle 2.

## Structure
- Shared package/header ahbl_defs:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
  - HSIZE codes (BYTE/HALF/WORD).
  - HRESP codes.
  - Bridge FSM state encoding.
- One combinational sub-module, ahbl_apb_strb (HSIZE, HADDR[1:0], HWRITE -> PSTRB), reused by future AHB slaves.

## Test plan
- Word write to 0x4000_0010, HWDATA=0xDEADBEEF, PREADY=1 -> PADDR=0x0010, PSTRB=4'hF, PWDATA=0xDEADBEEF in SETUP and ACCESS, HREADYOUT low for exactly 2 cycles, HRESP=0.
- Byte write to offset 0x3, then half write to offset 0x2 -> PSTRB=4'b1000, then 4'b1100. A read -> PSTRB=0.
- Read with PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 -> 5 wait states, then HRDATA=0x12345678 in DONE, with PADDR and PWRITE stable throughout.
- PSLVERR=1 with PREADY=1 -> ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1), HRDATA unchanged. HSIZE=3'b011 -> same response with PSEL never asserted.
- Back-to-back NONSEQ write then read, with the second captured in DONE -> PSEL low for exactly 1 cycle between transfers and both complete correctly. An HTRANS=BUSY transfer or HSEL=0 -> no PSEL and HREADYOUT stays 1.
- HRESETn asserted during ACCESS -> PSEL, PENABLE, HRESP=0 and HREADYOUT=1 immediately; after release, the next transfer proceeds normally.
